// File: rtl/aes_uart_pkg.sv
// Shared types and sizes for the AES block <-> UART byte path.
package aes_uart_pkg;

  localparam int BLOCK_BYTES = 16;
  localparam int BLOCK_W     = 128;
  localparam int BYTE_W      = 8;

  typedef enum logic [1:0] {IDLE, LOAD, WAIT, DONE} blk_state_e;
  typedef enum logic [1:0] {B_IDLE, B_START, B_DATA, B_STOP} bit_state_e;

endpackage

// File: rtl/uart_tx.sv
// 8N1 UART byte transmitter: one start bit, eight data bits LSB first, one stop bit.
//   state   | meaning
//   B_IDLE  | line high, waiting for start_tx
//   B_START | start bit (low)
//   B_DATA  | data bits 0..7, LSB first
//   B_STOP  | stop bit (high); byte_done in its last cycle
module uart_tx
  import aes_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic              clk,
  input  logic              rst_tx,
  input  logic              start_tx,
  input  logic [BYTE_W-1:0] data_tx,
  output logic              sig_tx,
  output logic              busy,
  output logic              byte_done
);

  localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BAUD_W-1:0] BAUD_RELOAD = BAUD_W'(CLKS_PER_BIT - 1);

  bit_state_e        state_q, state_d;
  logic [BAUD_W-1:0] baud_q, baud_d;
  logic [2:0]        idx_q, idx_d;
  logic [BYTE_W-1:0] data_q, data_d;
  logic              sig_q, sig_d;

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    idx_d   = idx_q;
    data_d  = data_q;
    sig_d   = sig_q;
    if (state_q != B_IDLE && baud_q != '0) begin
      baud_d = baud_q - 1'b1;
    end else begin
      case (state_q)
        B_IDLE: begin
          if (start_tx) begin
            state_d = B_START;
            baud_d  = BAUD_RELOAD;
            data_d  = data_tx;
            idx_d   = 3'd0;
            sig_d   = 1'b0;
          end
        end
        B_START: begin
          state_d = B_DATA;
          baud_d  = BAUD_RELOAD;
          sig_d   = data_q[0];
        end
        B_DATA: begin
          baud_d = BAUD_RELOAD;
          if (idx_q == 3'd7) begin
            state_d = B_STOP;
            sig_d   = 1'b1;
          end else begin
            idx_d  = idx_q + 3'd1;
            data_d = data_q >> 1;
            sig_d  = data_q[1];
          end
        end
        default: begin
          state_d = B_IDLE;
          sig_d   = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst_tx) begin
      state_q <= B_IDLE;
      baud_q  <= '0;
      idx_q   <= '0;
      data_q  <= '0;
      sig_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      sig_q   <= sig_d;
    end
  end

  assign sig_tx    = sig_q;
  assign busy      = (state_q != B_IDLE);
  assign byte_done = (state_q == B_STOP) && (baud_q == '0);

endmodule

// File: rtl/aes_to_tx.sv
// Serialises one 128-bit AES block as 16 UART bytes, byte 0 (data_in[7:0]) first.
//   state | meaning
//   IDLE  | ready_in high, waiting for a block
//   LOAD  | present next byte to uart_tx and pulse start
//   WAIT  | byte on the line; shift block on byte_done
//   DONE  | one-cycle done_tx pulse, then back to IDLE
module aes_to_tx
  import aes_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic               clk,
  input  logic               rst_tx,
  input  logic [BLOCK_W-1:0] data_in,
  input  logic               valid_in,
  output logic               ready_in,
  output logic               sig_tx,
  output logic               busy_tx,
  output logic               done_tx,
  output logic [BYTE_W-1:0]  tx_byte
);

  blk_state_e         state_q, state_d;
  logic [BLOCK_W-1:0] shreg_q, shreg_d;
  logic [3:0]         cnt_q, cnt_d;
  logic [BYTE_W-1:0]  tx_byte_q, tx_byte_d;
  logic               start_q, start_d;
  logic               ready_q, ready_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               uart_busy, byte_done;

  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    cnt_d     = cnt_q;
    tx_byte_d = tx_byte_q;
    start_d   = 1'b0;
    ready_d   = ready_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (valid_in && ready_q) begin
          shreg_d = data_in;
          cnt_d   = 4'd0;
          busy_d  = 1'b1;
          ready_d = 1'b0;
          state_d = LOAD;
        end
      end
      LOAD: begin
        if (!uart_busy) begin
          tx_byte_d = shreg_q[BYTE_W-1:0];
          start_d   = 1'b1;
          state_d   = WAIT;
        end
      end
      WAIT: begin
        if (byte_done) begin
          shreg_d = shreg_q >> BYTE_W;
          cnt_d   = cnt_q + 4'd1;  // 15 -> 0 wrap leaves cnt cleared for the next block
          if (cnt_q == 4'(BLOCK_BYTES - 1)) begin
            state_d = DONE;
            done_d  = 1'b1;
            busy_d  = 1'b0;
          end else begin
            state_d = LOAD;
          end
        end
      end
      default: begin
        ready_d = 1'b1;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_tx) begin
      state_q   <= IDLE;
      shreg_q   <= '0;
      cnt_q     <= '0;
      tx_byte_q <= '0;
      start_q   <= 1'b0;
      ready_q   <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      cnt_q     <= cnt_d;
      tx_byte_q <= tx_byte_d;
      start_q   <= start_d;
      ready_q   <= ready_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  uart_tx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_uart_tx (
    .clk       (clk),
    .rst_tx    (rst_tx),
    .start_tx  (start_q),
    .data_tx   (tx_byte_q),
    .sig_tx    (sig_tx),
    .busy      (uart_busy),
    .byte_done (byte_done)
  );

  assign ready_in = ready_q;
  assign busy_tx  = busy_q;
  assign done_tx  = done_q;
  assign tx_byte  = tx_byte_q;

endmodule

// File: tb/tb_aes_to_tx.sv
// Bench for aes_to_tx at CLKS_PER_BIT=4 and 2, against a cycle-offset line model.
module tb_aes_to_tx;

  logic         clk = 1'b0;
  logic         rst_tx = 1'b1;
  logic [127:0] data_in = '0;
  logic         valid_in = 1'b0;
  bit           sel = 1'b0;

  logic valid4, ready4, sig4, busy4, done4;
  logic valid2, ready2, sig2, busy2, done2;
  logic [7:0] txb4, txb2;
  logic ready_w, sig_w, busy_w, done_w;
  logic [7:0] txb_w;

  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  assign valid4  = valid_in && !sel;
  assign valid2  = valid_in && sel;
  assign ready_w = sel ? ready2 : ready4;
  assign sig_w   = sel ? sig2   : sig4;
  assign busy_w  = sel ? busy2  : busy4;
  assign done_w  = sel ? done2  : done4;
  assign txb_w   = sel ? txb2   : txb4;

  aes_to_tx #(.CLKS_PER_BIT(4)) dut4 (
    .clk(clk), .rst_tx(rst_tx), .data_in(data_in), .valid_in(valid4),
    .ready_in(ready4), .sig_tx(sig4), .busy_tx(busy4), .done_tx(done4), .tx_byte(txb4));

  aes_to_tx #(.CLKS_PER_BIT(2)) dut2 (
    .clk(clk), .rst_tx(rst_tx), .data_in(data_in), .valid_in(valid2),
    .ready_in(ready2), .sig_tx(sig2), .busy_tx(busy2), .done_tx(done2), .tx_byte(txb2));

  typedef struct {
    bit           s;
    logic [127:0] data;
    logic [7:0]   b0;
    logic [7:0]   b15;
  } vec_t;

  vec_t vecs[4];

  task automatic chk(input string name, input int t, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 25)
        $display("FAIL %s (C=%0d t=%0d): got %0h expected %0h", name, sel ? 2 : 4, t, act, exp);
    end
  endtask

  // Expected line level t cycles after the accept edge, from 8N1 framing arithmetic.
  function automatic logic exp_line(input logic [127:0] d, input int c, input int t);
    int p, tt, k, r, b;
    p = 10 * c + 2;
    if (t < 2) return 1'b1;
    tt = t - 2;
    k  = tt / p;
    if (k >= 16) return 1'b1;
    r = tt % p;
    if (r >= 10 * c) return 1'b1;
    b = r / c;
    if (b == 0) return 1'b0;
    if (b == 9) return 1'b1;
    return d[k * 8 + b - 1];
  endfunction

  // Call with valid_in/data_in set; the accept happens on the next edge.
  // hold keeps valid_in high afterwards with data_in = nxt.
  task automatic check_block(input logic [127:0] d, input bit hold, input logic [127:0] nxt,
                             output logic [7:0] dec0, output logic [7:0] dec15);
    int c, p, n, k, r, tt;
    logic [7:0] dec [16];
    c = sel ? 2 : 4;
    p = 10 * c + 2;
    n = 16 * p;
    for (int i = 0; i < 16; i++) dec[i] = 8'h00;
    @(posedge clk); #1;
    if (hold) data_in = nxt;
    else valid_in = 1'b0;
    for (int t = 0; t <= n + 1; t++) begin
      chk("sig_tx", t, 32'(sig_w), 32'(exp_line(d, c, t)));
      chk("done_tx", t, 32'(done_w), 32'(t == n));
      chk("busy_tx", t, 32'(busy_w), 32'(t < n));
      chk("ready_in", t, 32'(ready_w), 32'(t == n + 1));
      if (t >= 1 && t < n) begin
        k = (t - 1) / p;
        if (k > 15) k = 15;
        chk("tx_byte", t, 32'(txb_w), 32'(d[k * 8 +: 8]));
      end
      if (t >= 2 && t < n) begin
        tt = t - 2;
        k  = tt / p;
        r  = tt % p;
        if (r < 10 * c && (r % c) == c / 2 && (r / c) >= 1 && (r / c) <= 8)
          dec[k][(r / c) - 1] = sig_w;
      end
      if (t <= n) begin
        @(posedge clk); #1;
      end
    end
    for (int i = 0; i < 16; i++) chk("decoded_byte", i, 32'(dec[i]), 32'(d[i * 8 +: 8]));
    dec0  = dec[0];
    dec15 = dec[15];
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_sig"}, 0, 32'(sig_w), 32'd1);
    chk({tag, "_ready"}, 0, 32'(ready_w), 32'd1);
    chk({tag, "_busy"}, 0, 32'(busy_w), 32'd0);
    chk({tag, "_done"}, 0, 32'(done_w), 32'd0);
    chk({tag, "_txbyte"}, 0, 32'(txb_w), 32'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] d0, d15;
    logic [127:0] rd;
    int c, p, stop_t;

    vecs[0] = '{1'b0, 128'h0F0E0D0C0B0A09080706050403020100, 8'h00, 8'h0F};
    vecs[1] = '{1'b0, 128'hA5112233445566778899AABBCCDDEE3C, 8'h3C, 8'hA5};
    vecs[2] = '{1'b1, 128'h0F0E0D0C0B0A09080706050403020100, 8'h00, 8'h0F};
    vecs[3] = '{1'b1, 128'hFEDCBA9876543210FEDCBA9876543210, 8'h10, 8'hFE};

    rst_tx = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    sel = 1'b0; check_reset_state("reset4");
    sel = 1'b1; check_reset_state("reset2");
    rst_tx = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 4; i++) begin
      sel = vecs[i].s;
      data_in = vecs[i].data;
      valid_in = 1'b1;
      check_block(vecs[i].data, 1'b0, '0, d0, d15);
      chk("table_first_byte", i, 32'(d0), 32'(vecs[i].b0));
      chk("table_last_byte", i, 32'(d15), 32'(vecs[i].b15));
      @(posedge clk); #1;
    end

    // Busy ignore: all-ones block held on valid_in during block 1.
    sel = 1'b0;
    data_in = vecs[0].data;
    valid_in = 1'b1;
    check_block(vecs[0].data, 1'b1, {128{1'b1}}, d0, d15);
    check_block({128{1'b1}}, 1'b0, '0, d0, d15);
    chk("busy_ignore_b2_first", 0, 32'(d0), 32'hFF);

    // Extremes back-to-back, both bit rates.
    for (int s = 0; s < 2; s++) begin
      sel = (s == 1);
      @(posedge clk); #1;
      data_in = '0;
      valid_in = 1'b1;
      check_block('0, 1'b1, {128{1'b1}}, d0, d15);
      chk("zeros_last", s, 32'(d15), 32'h00);
      check_block({128{1'b1}}, 1'b0, '0, d0, d15);
      chk("ones_last", s, 32'(d15), 32'hFF);
    end

    // Mid-frame reset during byte 5, data bit 3 (line low for 0x05).
    sel = 1'b0;
    c = 4;
    p = 10 * c + 2;
    @(posedge clk); #1;
    data_in = vecs[0].data;
    valid_in = 1'b1;
    @(posedge clk); #1;
    valid_in = 1'b0;
    stop_t = 2 + 5 * p + 4 * c + 1;
    for (int t = 0; t < stop_t; t++) begin
      @(posedge clk); #1;
    end
    chk("pre_abort_sig", stop_t, 32'(sig_w), 32'd0);
    chk("pre_abort_busy", stop_t, 32'(busy_w), 32'd1);
    rst_tx = 1'b1;
    @(posedge clk); #1;
    check_reset_state("abort");
    rst_tx = 1'b0;
    @(posedge clk); #1;
    chk("abort_idle_sig", 0, 32'(sig_w), 32'd1);
    data_in = 128'h00112233445566778899AABBCCDDAA55;
    valid_in = 1'b1;
    check_block(128'h00112233445566778899AABBCCDDAA55, 1'b0, '0, d0, d15);
    chk("after_abort_first", 0, 32'(d0), 32'h55);

    // Random blocks on either instance with random idle gaps.
    for (int i = 0; i < 4; i++) begin
      sel = ($urandom_range(0, 1) == 1);
      repeat ($urandom_range(1, 4)) begin
        @(posedge clk); #1;
      end
      rd = {$urandom, $urandom, $urandom, $urandom};
      data_in = rd;
      valid_in = 1'b1;
      check_block(rd, 1'b0, '0, d0, d15);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
